// File: rtl/alu_seq_if.sv
// Bundle of the request, ALU and response channels of alu_sequencer.
// The master side is decode plus the ALU; the slave side is the sequencer.
interface alu_seq_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_acc;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic [CNT_W-1:0] ops_done;

    modport master (
        output req_valid, req_op, req_a, req_b, req_acc, rsp_ready,
               alu_result, alu_zero,
        input  req_ready, alu_a, alu_b, alu_control,
               rsp_valid, rsp_result, rsp_zero, rsp_err, ops_done
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_acc, rsp_ready,
               alu_result, alu_zero,
        output req_ready, alu_a, alu_b, alu_control,
               rsp_valid, rsp_result, rsp_zero, rsp_err, ops_done
    );
endinterface

// File: rtl/alu_sequencer.sv
// Three-state (IDLE/EXEC/RESP) initiator for the 16-bit combinational ALU.
// Optional accumulator source for operand A enabled by ALU_SEQ_ACCUM_EN.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Returns {err, alu_control}; illegal opcodes select the add function.
    function automatic logic [3:0] decode_op(input logic [3:0] op);
        logic [3:0] dec;
        case (op)
            4'b0000, 4'b0001, 4'b0010: dec = {1'b0, 3'b000};
            4'b0011:                   dec = {1'b0, 3'b001};
            4'b0100:                   dec = {1'b0, 3'b010};
            4'b0101:                   dec = {1'b0, 3'b011};
            4'b0110:                   dec = {1'b0, 3'b100};
            4'b0111:                   dec = {1'b0, 3'b101};
            4'b1000:                   dec = {1'b0, 3'b110};
            4'b1001:                   dec = {1'b0, 3'b111};
            4'b1011, 4'b1100:          dec = {1'b0, 3'b001};
            default:                   dec = {1'b1, 3'b000};
        endcase
        return dec;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             consume_s;
    logic [3:0]       dec_s;
    logic [WIDTH-1:0] src_a_s;

    logic             req_ready_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [2:0]       alu_ctrl_r;
    logic             err_r;
    logic             rsp_valid_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_zero_r;
    logic             rsp_err_r;
    logic [CNT_W-1:0] ops_done_r;

    assign dec_s = decode_op(bus.req_op);

`ifdef ALU_SEQ_ACCUM_EN
    logic [WIDTH-1:0] acc_r;

    // Accumulator tracks the last non-error result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_EXEC && !err_r) begin
            acc_r <= bus.alu_result;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Operand A source selection.
    always_comb begin
        src_a_s = bus.req_a;
        if (bus.req_acc) begin
            src_a_s = acc_r;
        end else begin
            src_a_s = bus.req_a;
        end
    end
`else
    logic unused_req_acc_s;

    assign unused_req_acc_s = bus.req_acc;
    assign src_a_s          = bus.req_a;
`endif

    // Next-state and handshake strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        consume_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    consume_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; req_ready is registered from the next state so it depends on state only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Operand and function registers change only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r    <= {WIDTH{1'b0}};
            alu_b_r    <= {WIDTH{1'b0}};
            alu_ctrl_r <= 3'b000;
            err_r      <= 1'b0;
        end else if (accept_s) begin
            alu_a_r    <= src_a_s;
            alu_b_r    <= bus.req_b;
            alu_ctrl_r <= dec_s[2:0];
            err_r      <= dec_s[3];
        end else begin
            alu_a_r    <= alu_a_r;
            alu_b_r    <= alu_b_r;
            alu_ctrl_r <= alu_ctrl_r;
            err_r      <= err_r;
        end
    end

    // Response capture at the end of EXEC; error responses carry zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= {WIDTH{1'b0}};
            rsp_zero_r   <= 1'b0;
            rsp_err_r    <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= err_r ? {WIDTH{1'b0}} : bus.alu_result;
            rsp_zero_r   <= err_r ? 1'b0 : bus.alu_zero;
            rsp_err_r    <= err_r;
        end else if (consume_s) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= rsp_result_r;
            rsp_zero_r   <= rsp_zero_r;
            rsp_err_r    <= rsp_err_r;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
            rsp_result_r <= rsp_result_r;
            rsp_zero_r   <= rsp_zero_r;
            rsp_err_r    <= rsp_err_r;
        end
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done_r <= {CNT_W{1'b0}};
        end else if (consume_s) begin
            ops_done_r <= ops_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ops_done_r <= ops_done_r;
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.alu_a       = alu_a_r;
    assign bus.alu_b       = alu_b_r;
    assign bus.alu_control = alu_ctrl_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_result  = rsp_result_r;
    assign bus.rsp_zero    = rsp_zero_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.ops_done    = ops_done_r;
endmodule
